// File: rtl/decodificador_display.sv
// Receiving end of the multiplexed 7-segment bus: recovers the tempo and
// velocidade digits by waiting for each phase's segment pattern to settle.
module decodificador_display #(
    parameter bit ATIVO_BAIXO = 1'b1,
    parameter int SETTLE      = 4,
    parameter int TIMEOUT     = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       seg_a,
    input  logic       seg_b,
    input  logic       seg_c,
    input  logic       seg_d,
    input  logic       seg_e,
    input  logic       seg_f,
    input  logic       seg_g,
    input  logic       clk_aux,
    output logic [3:0] tempo_val,
    output logic       tempo_ok,
    output logic [3:0] velocidade_val,
    output logic       velocidade_ok,
    output logic       novo_tempo,
    output logic       novo_velocidade,
    output logic       erro,
    output logic       sel_parado
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [8:0]    SETTLE_W = 9'(SETTLE);

    typedef enum logic [1:0] {ESPERA, ESTABILIZA, CAPTURA} estado_t;

    logic [6:0]    seg_meta, seg_sinc, segs, ref_seg, ref_prox;
    logic          aux_meta, aux_sinc, aux_ant, borda;
    logic          fase, fase_prox;
    logic [7:0]    cnt, cnt_prox;
    logic [TW-1:0] tcnt;
    logic [4:0]    dec;
    estado_t       estado, prox;

    function automatic logic [4:0] decodifica(input logic [6:0] p);
        case (p)
            7'b1111110: decodifica = {1'b1, 4'h0};
            7'b0110000: decodifica = {1'b1, 4'h1};
            7'b1101101: decodifica = {1'b1, 4'h2};
            7'b1111001: decodifica = {1'b1, 4'h3};
            7'b0110011: decodifica = {1'b1, 4'h4};
            7'b1011011: decodifica = {1'b1, 4'h5};
            7'b1011111: decodifica = {1'b1, 4'h6};
            7'b1110000: decodifica = {1'b1, 4'h7};
            7'b1111111: decodifica = {1'b1, 4'h8};
            7'b1111011: decodifica = {1'b1, 4'h9};
            7'b1110111: decodifica = {1'b1, 4'hA};
            7'b0011111: decodifica = {1'b1, 4'hB};
            7'b1001110: decodifica = {1'b1, 4'hC};
            7'b0111101: decodifica = {1'b1, 4'hD};
            7'b1001111: decodifica = {1'b1, 4'hE};
            7'b1000111: decodifica = {1'b1, 4'hF};
            default:    decodifica = {1'b0, 4'h0};
        endcase
    endfunction

    // Two-flop synchronisers plus a delayed copy of the select for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_meta <= '0;
            seg_sinc <= '0;
            aux_meta <= 1'b0;
            aux_sinc <= 1'b0;
            aux_ant  <= 1'b0;
        end else begin
            seg_meta <= {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g};
            seg_sinc <= seg_meta;
            aux_meta <= clk_aux;
            aux_sinc <= aux_meta;
            aux_ant  <= aux_sinc;
        end
    end

    assign segs  = ATIVO_BAIXO ? ~seg_sinc : seg_sinc;
    assign borda = aux_sinc ^ aux_ant;
    assign dec   = decodifica(ref_seg);

    always_ff @(posedge clk) begin
        if (reset) begin
            estado  <= ESPERA;
            cnt     <= '0;
            ref_seg <= '0;
            fase    <= 1'b0;
        end else begin
            estado  <= prox;
            cnt     <= cnt_prox;
            ref_seg <= ref_prox;
            fase    <= fase_prox;
        end
    end

    // Any select edge restarts settling, so a short-lived phase is never captured.
    always_comb begin
        prox      = estado;
        cnt_prox  = cnt;
        ref_prox  = ref_seg;
        fase_prox = fase;
        if (borda) begin
            prox      = ESTABILIZA;
            fase_prox = aux_sinc;
            ref_prox  = segs;
            cnt_prox  = '0;
        end else begin
            case (estado)
                ESPERA: prox = ESPERA;
                ESTABILIZA: begin
                    if (segs != ref_seg) begin
                        ref_prox = segs;
                        cnt_prox = '0;
                    end else begin
                        cnt_prox = cnt + 8'd1;
                        if ({1'b0, cnt} + 9'd2 >= SETTLE_W)
                            prox = CAPTURA;
                    end
                end
                CAPTURA: prox = ESPERA;
                default: prox = ESPERA;
            endcase
        end
    end

    // Capture results and the select-watchdog; the watchdog clears validity last.
    always_ff @(posedge clk) begin
        if (reset) begin
            tempo_val       <= 4'h0;
            tempo_ok        <= 1'b0;
            velocidade_val  <= 4'h0;
            velocidade_ok   <= 1'b0;
            novo_tempo      <= 1'b0;
            novo_velocidade <= 1'b0;
            erro            <= 1'b0;
            sel_parado      <= 1'b0;
            tcnt            <= '0;
        end else begin
            novo_tempo      <= 1'b0;
            novo_velocidade <= 1'b0;
            erro            <= 1'b0;
            if (estado == CAPTURA) begin
                erro <= ~dec[4];
                if (fase == 1'b0) begin
                    novo_tempo <= 1'b1;
                    tempo_ok   <= dec[4];
                    if (dec[4])
                        tempo_val <= dec[3:0];
                end else begin
                    novo_velocidade <= 1'b1;
                    velocidade_ok   <= dec[4];
                    if (dec[4])
                        velocidade_val <= dec[3:0];
                end
            end
            if (borda) begin
                tcnt       <= '0;
                sel_parado <= 1'b0;
            end else if (tcnt != T_MAX) begin
                tcnt <= tcnt + 1'b1;
                if (tcnt == T_LAST) begin
                    sel_parado    <= 1'b1;
                    tempo_ok      <= 1'b0;
                    velocidade_ok <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_decodificador_display.sv
// Directed bench for decodificador_display: table of phase captures plus
// hand-written edge-pair, watchdog and mid-capture reset sequences.
module tb_decodificador_display;

    logic       clk, reset, clk_aux;
    logic [6:0] bus;
    logic [3:0] tempo_val, velocidade_val;
    logic       tempo_ok, velocidade_ok, novo_tempo, novo_velocidade, erro, sel_parado;

    int checks = 0;
    int fails  = 0;

    decodificador_display #(.ATIVO_BAIXO(1'b1), .SETTLE(4), .TIMEOUT(100)) dut (
        .clk(clk), .reset(reset),
        .seg_a(bus[6]), .seg_b(bus[5]), .seg_c(bus[4]), .seg_d(bus[3]),
        .seg_e(bus[2]), .seg_f(bus[1]), .seg_g(bus[0]),
        .clk_aux(clk_aux),
        .tempo_val(tempo_val), .tempo_ok(tempo_ok),
        .velocidade_val(velocidade_val), .velocidade_ok(velocidade_ok),
        .novo_tempo(novo_tempo), .novo_velocidade(novo_velocidade),
        .erro(erro), .sel_parado(sel_parado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Patterns are active-high abcdefg; the bus is driven inverted.
    typedef struct {
        logic       aux;
        logic [6:0] pat;
        int         glitch_at;
        logic [6:0] pat2;
        int         flip_at;
        int         exp_t;
        int         exp_v;
        int         exp_e;
        logic [3:0] tval;
        logic       tok;
        logic [3:0] vval;
        logic       vok;
    } vec_t;

    vec_t vecs[14];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v, output int t_at, output int v_at, output int e_at,
                                 output int n_t, output int n_v, output int n_e);
        t_at = 0; v_at = 0; e_at = 0; n_t = 0; n_v = 0; n_e = 0;
        bus = ~v.pat;
        clk_aux = v.aux;
        for (int c = 1; c <= 32; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (novo_tempo) begin n_t++; if (t_at == 0) t_at = c; end
            if (novo_velocidade) begin n_v++; if (v_at == 0) v_at = c; end
            if (erro) begin n_e++; if (e_at == 0) e_at = c; end
            if (c == v.glitch_at) bus = ~v.pat2;
            if (c == v.flip_at) clk_aux = ~clk_aux;
        end
    endtask

    task automatic runVector(input string tag, input vec_t v);
        int t_at, v_at, e_at, n_t, n_v, n_e;
        applyStimulus(v, t_at, v_at, e_at, n_t, n_v, n_e);
        checkOutput({tag, " tempo pulse cycle"}, t_at, v.exp_t);
        checkOutput({tag, " velocidade pulse cycle"}, v_at, v.exp_v);
        checkOutput({tag, " erro pulse cycle"}, e_at, v.exp_e);
        checkOutput({tag, " tempo pulse count"}, n_t, (v.exp_t != 0) ? 1 : 0);
        checkOutput({tag, " velocidade pulse count"}, n_v, (v.exp_v != 0) ? 1 : 0);
        checkOutput({tag, " erro pulse count"}, n_e, (v.exp_e != 0) ? 1 : 0);
        checkOutput({tag, " tempo_val"}, tempo_val, v.tval);
        checkOutput({tag, " tempo_ok"}, tempo_ok, v.tok);
        checkOutput({tag, " velocidade_val"}, velocidade_val, v.vval);
        checkOutput({tag, " velocidade_ok"}, velocidade_ok, v.vok);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " tempo_val"}, tempo_val, 4'h0);
        checkOutput({tag, " tempo_ok"}, tempo_ok, 1'b0);
        checkOutput({tag, " velocidade_val"}, velocidade_val, 4'h0);
        checkOutput({tag, " velocidade_ok"}, velocidade_ok, 1'b0);
        checkOutput({tag, " novo_tempo"}, novo_tempo, 1'b0);
        checkOutput({tag, " novo_velocidade"}, novo_velocidade, 1'b0);
        checkOutput({tag, " erro"}, erro, 1'b0);
        checkOutput({tag, " sel_parado"}, sel_parado, 1'b0);
    endtask

    initial begin
        vec_t pair;
        int   sel_at, pulses;

        //            aux   pat         gl pat2        fl  t  v  e  tval tok vval vok
        vecs[0]  = '{1'b1, 7'b1110111, 0, 7'b0000000, 0, 0, 7, 0, 4'h0, 1'b0, 4'hA, 1'b1};
        vecs[1]  = '{1'b0, 7'b1111001, 0, 7'b0000000, 0, 7, 0, 0, 4'h3, 1'b1, 4'hA, 1'b1};
        vecs[2]  = '{1'b1, 7'b1001111, 0, 7'b0000000, 0, 0, 7, 0, 4'h3, 1'b1, 4'hE, 1'b1};
        vecs[3]  = '{1'b0, 7'b1011011, 0, 7'b0000000, 0, 7, 0, 0, 4'h5, 1'b1, 4'hE, 1'b1};
        vecs[4]  = '{1'b1, 7'b1110111, 0, 7'b0000000, 0, 0, 7, 0, 4'h5, 1'b1, 4'hA, 1'b1};
        vecs[5]  = '{1'b0, 7'b0011111, 2, 7'b1111111, 0, 9, 0, 0, 4'h8, 1'b1, 4'hA, 1'b1};
        vecs[6]  = '{1'b1, 7'b0110000, 2, 7'b1101101, 0, 0, 9, 0, 4'h8, 1'b1, 4'h2, 1'b1};
        vecs[7]  = '{1'b0, 7'b1111110, 0, 7'b0000000, 0, 7, 0, 0, 4'h0, 1'b1, 4'h2, 1'b1};
        vecs[8]  = '{1'b1, 7'b1010101, 0, 7'b0000000, 0, 0, 7, 7, 4'h0, 1'b1, 4'h2, 1'b0};
        vecs[9]  = '{1'b0, 7'b1000111, 0, 7'b0000000, 0, 7, 0, 0, 4'hF, 1'b1, 4'h2, 1'b0};
        vecs[10] = '{1'b1, 7'b0000000, 0, 7'b0000000, 0, 0, 7, 7, 4'hF, 1'b1, 4'h2, 1'b0};
        vecs[11] = '{1'b0, 7'b0000000, 0, 7'b0000000, 0, 7, 0, 7, 4'hF, 1'b0, 4'h2, 1'b0};
        vecs[12] = '{1'b1, 7'b0111101, 0, 7'b0000000, 0, 0, 7, 0, 4'hF, 1'b0, 4'hD, 1'b1};
        vecs[13] = '{1'b0, 7'b1110000, 0, 7'b0000000, 0, 7, 0, 0, 4'h7, 1'b1, 4'hD, 1'b1};

        reset   = 1'b1;
        clk_aux = 1'b0;
        bus     = ~7'b1111001;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        reset = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 14; i++)
            runVector($sformatf("vec%0d", i), vecs[i]);

        // Select pulses high for only two cycles: only the tempo phase survives.
        pair = '{1'b1, 7'b0110011, 0, 7'b0000000, 2, 9, 0, 0, 4'h4, 1'b1, 4'hD, 1'b1};
        runVector("edge_pair", pair);

        // Watchdog: one velocidade capture, then the select stops toggling.
        bus     = ~7'b1011111;
        clk_aux = 1'b1;
        sel_at  = 0;
        for (int c = 1; c <= 200 && sel_at == 0; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 7) checkOutput("timeout novo_velocidade", novo_velocidade, 1'b1);
            if (c == 102) begin
                checkOutput("pre-timeout sel_parado", sel_parado, 1'b0);
                checkOutput("pre-timeout tempo_ok", tempo_ok, 1'b1);
                checkOutput("pre-timeout velocidade_ok", velocidade_ok, 1'b1);
            end
            if (sel_parado) sel_at = c;
        end
        checkOutput("sel_parado cycle", sel_at, 103);
        checkOutput("timeout tempo_ok", tempo_ok, 1'b0);
        checkOutput("timeout velocidade_ok", velocidade_ok, 1'b0);
        checkOutput("timeout velocidade_val", velocidade_val, 4'h6);
        checkOutput("timeout tempo_val", tempo_val, 4'h4);

        // Next toggle clears the watchdog, then reset lands mid-settling.
        bus     = ~7'b1111011;
        clk_aux = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 2) checkOutput("sel_parado held", sel_parado, 1'b1);
            if (c == 3) checkOutput("sel_parado cleared", sel_parado, 1'b0);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkAllZero("mid-capture reset");
        reset  = 1'b0;
        pulses = 0;
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (novo_tempo || novo_velocidade || erro) pulses++;
        end
        checkOutput("post-reset pulses", pulses, 0);
        checkAllZero("post-reset idle");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/decodificador_display.md
Name: decodificador_display

Overview:
- Receiving end of the time-multiplexed 7-segment bus. Samples the shared segment lines (seg_a..seg_g) together with the phase-select line (clk_aux) and recovers the two multiplexed digits: tempo (action count) and velocidade (speed).
- Decodes each phase's segment pattern back to a 4-bit hex value and flags patterns that match no digit.
- Used as an on-board/bench monitor and as a self-check for the display path.

Parameters:
- ATIVO_BAIXO, 1, 1 = segment lines are active-low (lit = 0); 0 = active-high.
- SETTLE, 4, consecutive stable clk cycles required on the segment lines before a phase is captured (legal range 1..255).
- TIMEOUT, 1000000, clk cycles without a clk_aux edge before sel_parado asserts and both *_ok flags clear.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- seg_a..seg_g  input  1 each  multiplexed segment lines (asynchronous to clk).
- clk_aux  input  1  phase select (asynchronous). 0 = tempo phase, 1 = velocidade phase.
- tempo_val  output  4  last decoded tempo digit.
- tempo_ok  output  1  tempo_val holds a valid capture.
- velocidade_val  output  4  last decoded velocidade digit.
- velocidade_ok  output  1  velocidade_val holds a valid capture.
- novo_tempo  output  1  one-cycle pulse on each tempo capture (valid or not).
- novo_velocidade  output  1  one-cycle pulse on each velocidade capture (valid or not).
- erro  output  1  one-cycle pulse when a captured pattern is not in the decode table.
- sel_parado  output  1  level; clk_aux has not toggled for TIMEOUT cycles.

Behaviour:
- Synchronisation
  - seg_a..g (7 bits) and clk_aux each pass through a 2-flop synchroniser.
  - An edge is detected when synchronised clk_aux differs from its 1-cycle-delayed copy.
- Polarity: if ATIVO_BAIXO=1, the synchronised segments are inverted before use; all patterns below are active-high, ordered abcdefg.
- Decode table:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111
  - Any other pattern, including blank 0000000, is invalid.
- FSM states:
  - ESPERA: idle.
  - ESTABILIZA: cnt counts stable cycles; ref holds a segment snapshot; fase holds the phase.
  - CAPTURA: one cycle.
- Transitions
  - ESPERA -> ESTABILIZA on an edge: fase <= new select value, ref <= current segments, cnt <= 0.
  - In ESTABILIZA:
    - New edge: restart (fase, ref and cnt reloaded); the old phase is discarded.
    - Segments differ from ref: ref <= segments, cnt <= 0.
    - Segments equal ref: cnt++.
    - When cnt reaches SETTLE-1 with segments still equal: -> CAPTURA.
  - CAPTURA decodes ref for fase, then -> ESPERA. An edge arriving in the CAPTURA cycle is still honoured: the next state is ESTABILIZA.
- Capture rules
  - Valid pattern: *_val <= digit, *_ok <= 1, novo_* pulses.
  - Invalid pattern: *_val holds, *_ok <= 0, novo_* and erro pulse together.
- Latency
  - The clk_aux input edge, with segments already stable, produces the novo_* pulse exactly SETTLE+3 clk cycles later.
  - Breakdown: 2 sync cycles, 1 detect, SETTLE-1 count cycles, 1 CAPTURA registered output.
- Timeout
  - A free-running counter resets on every edge and saturates at TIMEOUT.
  - On reaching TIMEOUT: sel_parado <= 1, tempo_ok <= 0, velocidade_ok <= 0.
  - The next edge clears sel_parado in the edge cycle.
- Reset
  - FSM -> ESPERA; all outputs 0 (*_val = 4'h0, flags 0, pulses 0); synchroniser flops 0 (pre-inversion); counters 0.
  - Reset mid-ESTABILIZA aborts the capture; no pulse is generated.
- All outputs are registered.

Test Plan:
- ATIVO_BAIXO=1, SETTLE=4. Segment lines = ~1111001, then clk_aux 1->0 and held -> novo_tempo exactly 7 cycles after the edge; tempo_val=3, tempo_ok=1; erro=0.
- Alternate phases: clk_aux=0 with "5" (1011011), clk_aux=1 with "A" (1110111), period 64 clk -> tempo_val=5, velocidade_val=A; pulses alternate; no erro.
- Glitch: segments change 2 cycles after the edge, then hold "8" -> capture 8; the pulse is delayed by 2 extra cycles; pattern "b" shown before the change is never reported.
- Invalid pattern 1010101 (or blank) in the velocidade phase -> novo_velocidade and erro pulse in the same cycle; velocidade_ok=0; velocidade_val unchanged.
- Edge pair 2 cycles apart (clk_aux 0->1->0) -> only one capture, a tempo capture; no velocidade pulse.
- TIMEOUT=100: stop toggling clk_aux -> sel_parado=1 and both *_ok=0 at cycle 100. Next toggle -> sel_parado=0; reassert reset mid-ESTABILIZA -> all outputs 0 and no pulse.
